// File: rtl/alu_pkg.sv
// Shared ALU constants, FSM state type and flag helper.
// Imported by alu, rr_pick users and alu_arbiter.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   localparam int FLG_ZERO  = 0;
   localparam int FLG_CARRY = 1;
   localparam int FLG_SIGN  = 2;
   localparam int FLG_PAR   = 3;
   localparam int FLG_OVF   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic [4:0] mk_flags(
      input logic [3:0] out,
      input logic       carry,
      input logic       ovf
   );
      logic [4:0] f;
      f            = '0;
      f[FLG_ZERO]  = ~|out;
      f[FLG_CARRY] = carry;
      f[FLG_SIGN]  = out[3];
      f[FLG_PAR]   = ~^out;
      f[FLG_OVF]   = ovf;
      return f;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between issue units and alu_arbiter.
// master: requester side; slave: arbiter side.
interface alu_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [4*NUM_REQ-1:0] req_a;
   logic [4*NUM_REQ-1:0] req_b;
   logic [2*NUM_REQ-1:0] req_sel;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [1:0]           resp_id;
   logic [3:0]           resp_out;
   logic [4:0]           resp_flags;
   logic                 resp_err;
   logic                 busy;

   modport master (
      output req_valid, req_a, req_b, req_sel, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_out,
      input  resp_flags, resp_err, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sel, resp_ready,
      output req_ready, resp_valid, resp_id, resp_out,
      output resp_flags, resp_err, busy
   );
endinterface

// File: rtl/alu.sv
// Existing 4-bit ALU: add/sub/mul with {ovf,par,sign,carry,zero}.
// Ports: i_a, i_b operands, i_sel op; o_out result, o_flags.
module alu
   import alu_pkg::*;
(
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic [1:0] i_sel,
   output logic [3:0] o_out,
   output logic [4:0] o_flags
);

   logic [7:0] w_prod;
   logic [4:0] w_res;
   logic       w_ovf;

   assign w_prod = {4'b0, i_a} * {4'b0, i_b};

   always_comb begin
      w_res = '0;
      unique case (i_sel)
         OP_ADD:  w_res = {1'b0, i_a} + {1'b0, i_b};
         OP_SUB:  w_res = {1'b0, i_a} - {1'b0, i_b};
         OP_MUL:  w_res = w_prod[4:0];
         default: w_res = '0;
      endcase
   end

   // Overflow: operands share a sign bit and the result's differs.
   assign w_ovf = (i_a[3] ~^ i_b[3]) & (w_res[3] ^ i_a[3]);

   assign o_out   = w_res[3:0];
   assign o_flags = (i_sel == OP_DIV) ? 5'd0
                  : mk_flags(w_res[3:0], w_res[4], w_ovf);

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid from i_ptr upward.
// Ports: i_valid, i_ptr in; o_grant index, o_any out.
module rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [1:0]         i_ptr,
   output logic [1:0]         o_grant,
   output logic               o_any
);

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [2*NUM_REQ-1:0] w_rot;
   logic [2:0]           w_sum;

   // Rotate so bit k is requester (ptr+k) mod NUM_REQ.
   assign w_dbl = {i_valid, i_valid};
   assign w_rot = w_dbl >> i_ptr;

   always_comb begin
      w_sum = '0;
      o_any = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_sum = {1'b0, i_ptr} + 3'(i);
            o_any = 1'b1;
         end
      end
      o_grant = (w_sum >= 3'(NUM_REQ))
              ? 2'(w_sum - 3'(NUM_REQ))
              : w_sum[1:0];
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one 4-bit ALU among NUM_REQ requesters.
// Ports: clk, reset (sync, high); bus = alu_arbiter_if.slave.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic         clk,
   input  logic         reset,
   alu_arbiter_if.slave bus
);

   state_t             r_state;
   state_t             w_next;
   logic [1:0]         r_ptr;
   logic [1:0]         r_id;
   logic [1:0]         r_rid;
   logic [1:0]         r_sel;
   logic [3:0]         r_a;
   logic [3:0]         r_b;
   logic [3:0]         r_out;
   logic [4:0]         r_flags;
   logic               r_err;
   logic [1:0]         w_grant;
   logic               w_any;
   logic               w_take;
   logic               w_fire;
   logic [3:0]         w_ga;
   logic [3:0]         w_gb;
   logic [1:0]         w_gsel;
   logic [3:0]         w_alu_out;
   logic [4:0]         w_alu_flags;
   logic [3:0]         w_q;
   logic [2:0]         w_inc;
   logic [1:0]         w_ptr_nxt;
   logic [NUM_REQ-1:0] w_ready;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_valid (bus.req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_any   (w_any)
   );

   // Driven only from latched operands, stable across EXEC.
   alu u_alu (
      .i_a     (r_a),
      .i_b     (r_b),
      .i_sel   (r_sel),
      .o_out   (w_alu_out),
      .o_flags (w_alu_flags)
   );

   assign w_take = (r_state == ST_IDLE) && w_any;
   assign w_fire = (r_state == ST_RESP) && bus.resp_ready;
   assign w_q    = (r_b == 4'd0) ? 4'd0 : r_a / r_b;

   assign w_inc     = {1'b0, r_rid} + 3'd1;
   assign w_ptr_nxt = (w_inc >= 3'(NUM_REQ)) ? 2'd0 : w_inc[1:0];

   always_comb begin
      w_ga   = '0;
      w_gb   = '0;
      w_gsel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant == 2'(i)) begin
            w_ga   = bus.req_a[4*i +: 4];
            w_gb   = bus.req_b[4*i +: 4];
            w_gsel = bus.req_sel[2*i +: 2];
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (w_take) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = (w_grant == 2'(i));
         end
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (w_any) w_next = ST_EXEC;
         ST_EXEC: w_next = ST_RESP;
         ST_RESP: if (bus.resp_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_id    <= '0;
         r_rid   <= '0;
         r_sel   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_out   <= '0;
         r_flags <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_a   <= w_ga;
            r_b   <= w_gb;
            r_sel <= w_gsel;
            r_id  <= w_grant;
         end
         if (r_state == ST_EXEC) begin
            r_rid <= r_id;
            if (r_sel == OP_DIV) begin
               r_out   <= w_q;
               r_err   <= (r_b == 4'd0);
               r_flags <= (r_b == 4'd0) ? 5'd0
                        : mk_flags(w_q, 1'b0, 1'b0);
            end else begin
               r_out   <= w_alu_out;
               r_flags <= w_alu_flags;
               r_err   <= 1'b0;
            end
         end
         if (w_fire) r_ptr <= w_ptr_nxt;
      end
   end

   assign bus.req_ready  = w_ready;
   assign bus.resp_valid = (r_state == ST_RESP);
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.resp_id    = r_rid;
   assign bus.resp_out   = r_out;
   assign bus.resp_flags = r_flags;
   assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter.
// Reference: transaction-level round-robin + arithmetic model.
module tb_alu_arbiter;

   localparam int N = 4;

   logic clk;
   logic reset;
   int   cyc;
   int   n_chk;
   int   n_err;
   int   mptr;
   int   acc_cyc;
   int   prev_acc;

   logic [3:0] va;
   int         ta[N];
   int         tb[N];
   int         ts[N];

   alu_arbiter_if #(.NUM_REQ(N)) bus();

   alu_arbiter #(
      .NUM_REQ (N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {err, ovf, par, sign, carry, zero, out[3:0]}
   function automatic logic [9:0] ref_op(input int a,
                                         input int b,
                                         input int s);
      int o, c, v;
      o = 0; c = 0; v = 0;
      case (s)
         0: begin o = (a + b) % 16; c = int'((a + b) > 15); end
         1: begin o = (a - b + 16) % 16; c = int'(a < b); end
         2: begin o = (a * b) % 16; c = ((a * b) / 16) % 2; end
         default: begin
            if (b == 0) return 10'b10_0000_0000;
            o = a / b;
         end
      endcase
      if (s != 3)
         v = int'(((a >= 8) == (b >= 8)) && ((o >= 8) != (a >= 8)));
      return {1'b0, 1'(v), 1'($countones(4'(o)) % 2 == 0),
              1'(o >= 8), 1'(c), 1'(o == 0), 4'(o)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      logic [15:0] pa, pb;
      logic [7:0]  ps;
      for (int i = 0; i < N; i++) begin
         pa[4*i +: 4] = 4'(ta[i]);
         pb[4*i +: 4] = 4'(tb[i]);
         ps[2*i +: 2] = 2'(ts[i]);
      end
      bus.req_valid = va;
      bus.req_a     = pa;
      bus.req_b     = pb;
      bus.req_sel   = ps;
   endtask

   task automatic new_data(input int i);
      ta[i] = int'($urandom_range(0, 15));
      tb[i] = ($urandom_range(0, 5) == 0) ? 0
            : int'($urandom_range(0, 15));
      ts[i] = int'($urandom_range(0, 3));
   endtask

   task automatic run_txn(input int k, input bit keep);
      int g, ix;
      logic [9:0] e;
      tick();
      drive();
      bus.resp_ready = 1'b0;
      g = -1;
      for (int j = 0; j < N; j++) begin
         ix = (mptr + j) % N;
         if (g < 0 && va[ix]) g = ix;
      end
      @(negedge clk);
      if (g < 0) begin
         chk("idle_rdy", 32'(bus.req_ready), 0);
         chk("idle_busy", 32'(bus.busy), 0);
         return;
      end
      chk("grant", 32'(bus.req_ready), 1 << g);
      chk("acc_busy", 32'(bus.busy), 0);
      prev_acc = acc_cyc;
      acc_cyc  = cyc;
      e = ref_op(ta[g], tb[g], ts[g]);
      tick();
      if (keep) new_data(g);
      else va[g] = 1'b0;
      drive();
      @(negedge clk);
      chk("exec_rdy", 32'(bus.req_ready), 0);
      chk("exec_rv", 32'(bus.resp_valid), 0);
      chk("exec_busy", 32'(bus.busy), 1);
      tick();
      bus.resp_ready = (k == 0);
      for (int j = 0; j <= k; j++) begin
         if (j > 0) begin
            tick();
            bus.resp_ready = (j == k);
         end
         @(negedge clk);
         chk("resp_rv", 32'(bus.resp_valid), 1);
         chk("resp_id", 32'(bus.resp_id), 32'(g));
         chk("resp_out", 32'(bus.resp_out), 32'(e[3:0]));
         chk("resp_flg", 32'(bus.resp_flags), 32'(e[8:4]));
         chk("resp_err", 32'(bus.resp_err), 32'(e[9]));
         chk("resp_rdy", 32'(bus.req_ready), 0);
         chk("resp_busy", 32'(bus.busy), 1);
      end
      mptr = (g + 1) % N;
   endtask

   task automatic set_one(input int i, input int a,
                          input int b, input int s);
      va    = '0;
      va[i] = 1'b1;
      ta[i] = a;
      tb[i] = b;
      ts[i] = s;
   endtask

   initial begin
      n_chk    = 0;
      n_err    = 0;
      cyc      = 0;
      mptr     = 0;
      acc_cyc  = 0;
      prev_acc = 0;
      va       = '0;
      for (int i = 0; i < N; i++) begin
         ta[i] = 0; tb[i] = 0; ts[i] = 0;
      end
      reset          = 1'b1;
      bus.resp_ready = 1'b0;
      drive();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_rv", 32'(bus.resp_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_rdy", 32'(bus.req_ready), 0);
      chk("rst_out", 32'(bus.resp_out), 0);
      chk("rst_flg", 32'(bus.resp_flags), 0);
      chk("rst_id", 32'(bus.resp_id), 0);
      chk("rst_err", 32'(bus.resp_err), 0);

      // All requesters valid: rotation 0,1,2,3,0 every 3 cycles.
      va = 4'hF;
      for (int i = 0; i < N; i++) new_data(i);
      for (int n = 0; n < 5; n++) begin
         run_txn(0, 1'b1);
         if (n > 0) chk("spacing", 32'(acc_cyc - prev_acc), 3);
      end

      set_one(0, 7, 9, 0);
      run_txn(0, 1'b0);
      chk("add_out", 32'(bus.resp_out), 0);
      chk("add_flg", 32'(bus.resp_flags), 32'h0B);

      set_one(1, 3, 5, 1);
      run_txn(0, 1'b0);
      chk("sub_out", 32'(bus.resp_out), 32'hE);
      chk("sub_flg", 32'(bus.resp_flags), 32'h16);

      set_one(2, 5, 3, 2);
      run_txn(0, 1'b0);
      chk("mul_out", 32'(bus.resp_out), 32'hF);
      chk("mul_flg", 32'(bus.resp_flags), 32'h1C);

      set_one(3, 9, 2, 3);
      run_txn(0, 1'b0);
      chk("div_out", 32'(bus.resp_out), 4);
      chk("div_err", 32'(bus.resp_err), 0);

      set_one(3, 9, 0, 3);
      run_txn(0, 1'b0);
      chk("dz_out", 32'(bus.resp_out), 0);
      chk("dz_flg", 32'(bus.resp_flags), 0);
      chk("dz_err", 32'(bus.resp_err), 1);

      // Backpressure with others pending.
      va = 4'hF;
      for (int i = 0; i < N; i++) new_data(i);
      run_txn(5, 1'b0);
      run_txn(0, 1'b0);

      // Reset while in EXEC discards the op and the pointer.
      va = 4'hF;
      ta[1] = 15; tb[1] = 15; ts[1] = 2;
      tick();
      drive();
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("pre_rst_g", 32'(bus.req_ready), 1 << mptr);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 1);
      tick();
      reset = 1'b0;
      va    = '0;
      drive();
      @(negedge clk);
      chk("x_rv", 32'(bus.resp_valid), 0);
      chk("x_busy", 32'(bus.busy), 0);
      chk("x_rdy", 32'(bus.req_ready), 0);
      chk("x_out", 32'(bus.resp_out), 0);
      chk("x_flg", 32'(bus.resp_flags), 0);
      chk("x_id", 32'(bus.resp_id), 0);
      chk("x_err", 32'(bus.resp_err), 0);
      mptr = 0;
      va   = 4'hF;
      run_txn(0, 1'b0);
      chk("x_first", 32'(bus.resp_id), 0);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         for (int i = 0; i < N; i++) begin
            if (va[i] && $urandom_range(0, 4) == 0) begin
               va[i] = 1'b0;
            end else if (!va[i] && $urandom_range(0, 1) == 1) begin
               va[i] = 1'b1;
               new_data(i);
            end
         end
         run_txn(int'($urandom_range(0, 3)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 4-bit ALU datapath among up to four requesters, using round-robin arbitration and valid/ready handshakes on both the request and response sides.
- Latches the granted operands and drives the existing alu block with stable inputs for a full cycle.
- Registers the result and flags, then returns them tagged with the requester ID.
- Sits between the per-unit issue logic and the shared ALU; one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters; legal values 2..4; requester IDs are always 2 bits wide.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept strobe; at most one bit high
- req_a  input  4*NUM_REQ  operand A, requester i at bits [4i+3:4i]
- req_b  input  4*NUM_REQ  operand B, same packing as req_a
- req_sel  input  2*NUM_REQ  operation per requester: 0 add, 1 sub, 2 mul, 3 div
- resp_valid  output  1  response valid
- resp_ready  input  1  response consumer ready
- resp_id  output  2  index of the requester that issued the operation
- resp_out  output  4  result
- resp_flags  output  5  {overflow, parity, sign, carry, zero}
- resp_err  output  1  divide-by-zero indication
- busy  output  1  high in any state other than IDLE

Behaviour:
- FSM states IDLE, EXEC, RESP. Reset puts the FSM in IDLE, sets rr_ptr=0, and clears every output and every operand/result register to 0.
- IDLE transition:
  - If any req_valid is high, grant the first valid index found searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[grant] is high combinationally in that same cycle; that cycle is the handshake.
  - Latch a, b, sel and grant ID, then go to EXEC.
  - If no req_valid is high, stay in IDLE; req_ready is all 0.
- req_ready is 0 in EXEC and RESP.
- Requesters hold a/b/sel stable while valid and not ready. A requester may drop valid before it is granted without penalty.
- EXEC (exactly 1 cycle):
  - The alu instance sees only the latched operands, so its inputs are stable for the whole cycle.
  - At the clock edge, capture {carry,out} and the flags into result registers, then go to RESP.
- Operation rules:
  - sel 0/1/2: result and flags come from the alu instance. Add/sub/mul produce a 5-bit {carry,out}, truncated product for mul.
  - sel 3 with B≠0: computed in-block. out=A/B (unsigned, truncating), carry=0, overflow=0, zero/sign/parity derived from out.
  - sel 3 with B=0: resp_err=1, resp_out=0, resp_flags=0.
- Flag definitions: zero=~|out, sign=out[3], parity=~^out (1 = even number of ones).
- RESP:
  - resp_valid=1. All resp_* fields hold stable until resp_valid && resp_ready.
  - On that handshake: rr_ptr=(grant+1) mod NUM_REQ, resp_valid drops the next cycle, go to IDLE.
- Latency: accept at cycle T → resp_valid at T+2.
- Throughput: a new accept can occur no earlier than the cycle after the response handshake, so back-to-back operations occupy 3 cycles each.
- Boundary conditions:
  - All requesters valid simultaneously: grants rotate 0,1,2,3,0.
  - A single requester valid continuously is granted every operation; no starvation of others, since rr_ptr moves past it.
  - resp_ready held low indefinitely: stay in RESP with no new grants.
  - Reset in EXEC or RESP: the operation is discarded, resp_valid is 0 the cycle after reset, rr_ptr=0.
  - req_valid bits at index ≥ NUM_REQ do not exist; the rr_ptr wrap uses NUM_REQ.

Decomposition:
- Shared package alu_pkg holds:
  - operation constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - flag bit positions FLG_ZERO=0 .. FLG_OVF=4;
  - a flag-derivation function used for the in-block div path.
- One natural sub-module: rr_pick, a combinational round-robin priority picker taking (valid vector, pointer) and returning (grant index, any).
- The existing alu block is instantiated once inside alu_arbiter.

Test Plan:
- Req0 add A=7 B=9 → req_ready[0] at T, resp_valid at T+2: resp_out=0, resp_flags=5'b01011, resp_id=0, resp_err=0.
- Req1 sub A=3 B=5 → resp_out=4'hE, resp_flags=5'b10110, resp_id=1. Req2 mul A=5 B=3 → resp_out=4'hF, resp_flags=5'b11100.
- Req3 div A=9 B=2 → resp_out=4, resp_flags=0, resp_err=0. Then div A=9 B=0 → resp_out=0, resp_flags=0, resp_err=1.
- All four req_valid high from reset with resp_ready=1 → resp_id sequence 0,1,2,3,0, one accept every 3 cycles, req_ready one-hot.
- Backpressure: resp_ready low for 5 cycles while other requests pend → resp fields stable, busy=1, no req_ready. On release, the next grant comes one cycle after the handshake.
- Assert reset during EXEC → next cycle FSM in IDLE, resp_valid=0, all outputs 0. The next request from req2 with all valid is granted req0 first (rr_ptr=0).
